// File: rtl/airlock_interlock_ctrl.sv
// Purpose: two-door airlock sequencer with pump countdown, refusal flag and cycle reversal.
// Latency: every output is registered; an input sampled on a rising edge shows up after that edge.
// Backpressure: none; level requests that are illegal in the current state are dropped and flagged on bad_req_o.
// Build option: define AUTO_CLOSE_EN to force doors shut after DOOR_TIMEOUT ticks (adds door_forced_o).
module airlock_interlock_ctrl #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned EVAC_TIME    = 8,
    parameter int unsigned PRESS_TIME   = 5,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned DOOR_TIMEOUT = 10
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             inner_sw_i,
    input  logic             outer_sw_i,
    input  logic             evac_req_i,
    input  logic             press_req_i,
    output logic             inner_open_o,
    output logic             outer_open_o,
    output logic             pressurized_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] time_left_o,
    output logic [2:0]       state_o,
    output logic             bad_req_o
`ifdef AUTO_CLOSE_EN
    ,
    output logic             door_forced_o
`endif
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        P_CLOSED   = 3'd0,
        INNER_OPEN = 3'd1,
        EVAC       = 3'd2,
        V_CLOSED   = 3'd3,
        OUTER_OPEN = 3'd4,
        PRESS      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tl_q, tl_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             bad_q, bad_d;
    logic             inner_open_q, inner_open_d;
    logic             outer_open_q, outer_open_d;
    logic             press_q, press_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             presc_run;
    logic             inner_sw;
    logic             outer_sw;
    logic             door_expire;

    // Remaining time after a reversal: the fraction already pumped is undone,
    // rescaled to the opposite direction's duration, never less than one tick.
    function automatic logic [CNT_W-1:0] reverse_time(
        input logic [CNT_W-1:0] left,
        input int unsigned      from_time,
        input int unsigned      to_time
    );
        int unsigned done;
        int unsigned result;
        done   = (32'(left) * to_time) / from_time;
        result = to_time - done;
        if (result == 0) begin
            result = 1;
        end
        return CNT_W'(result);
    endfunction

    assign tick = (presc_q == PW'(TICK_DIV - 1));

`ifdef AUTO_CLOSE_EN
    localparam int unsigned DCW = (DOOR_TIMEOUT > 1) ? $clog2(DOOR_TIMEOUT + 1) : 1;

    logic [DCW-1:0] door_cnt_q, door_cnt_d;
    logic           inner_lock_q, inner_lock_d;
    logic           outer_lock_q, outer_lock_d;
    logic           forced_q, forced_d;

    // A locked-out door switch reads as released until the operator lets go of it.
    assign inner_sw  = inner_sw_i & ~inner_lock_q;
    assign outer_sw  = outer_sw_i & ~outer_lock_q;
    assign presc_run = (state_q == EVAC) || (state_q == PRESS) ||
                       (state_q == INNER_OPEN) || (state_q == OUTER_OPEN);
    assign door_expire = tick && (door_cnt_q == DCW'(DOOR_TIMEOUT - 1)) &&
                         (((state_q == INNER_OPEN) && inner_sw) ||
                          ((state_q == OUTER_OPEN) && outer_sw));

    // Door-open tick counter, forced-close pulse and per-door lockout update
    always_comb begin
        door_cnt_d   = '0;
        if (((state_q == INNER_OPEN) || (state_q == OUTER_OPEN)) && (state_d == state_q)) begin
            door_cnt_d = tick ? (door_cnt_q + DCW'(1)) : door_cnt_q;
        end
        forced_d     = door_expire;
        inner_lock_d = (door_expire && (state_q == INNER_OPEN)) || (inner_lock_q && inner_sw_i);
        outer_lock_d = (door_expire && (state_q == OUTER_OPEN)) || (outer_lock_q && outer_sw_i);
    end

    // Auto-close bookkeeping registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            door_cnt_q   <= '0;
            inner_lock_q <= 1'b0;
            outer_lock_q <= 1'b0;
            forced_q     <= 1'b0;
        end else begin
            door_cnt_q   <= door_cnt_d;
            inner_lock_q <= inner_lock_d;
            outer_lock_q <= outer_lock_d;
            forced_q     <= forced_d;
        end
    end

    assign door_forced_o = forced_q;
`else
    assign inner_sw    = inner_sw_i;
    assign outer_sw    = outer_sw_i;
    assign presc_run   = (state_q == EVAC) || (state_q == PRESS);
    assign door_expire = 1'b0;
`endif

    // Next state, countdown value and refusal flag for the current state
    always_comb begin
        state_d = state_q;
        tl_d    = tl_q;
        bad_d   = 1'b0;
        case (state_q)
            P_CLOSED: begin
                tl_d  = '0;
                bad_d = outer_sw | press_req_i;
                // Door request wins over a pump request in the same cycle.
                if (inner_sw) begin
                    state_d = INNER_OPEN;
                end else if (evac_req_i) begin
                    state_d = EVAC;
                    tl_d    = CNT_W'(EVAC_TIME);
                end
            end
            INNER_OPEN: begin
                tl_d  = '0;
                bad_d = outer_sw | evac_req_i | press_req_i;
                if (!inner_sw || door_expire) begin
                    state_d = P_CLOSED;
                end
            end
            EVAC: begin
                bad_d = inner_sw | outer_sw;
                if (press_req_i) begin
                    state_d = PRESS;
                    tl_d    = reverse_time(tl_q, EVAC_TIME, PRESS_TIME);
                end else if (tick) begin
                    if (tl_q <= CNT_W'(1)) begin
                        state_d = V_CLOSED;
                        tl_d    = '0;
                    end else begin
                        tl_d = tl_q - CNT_W'(1);
                    end
                end
            end
            V_CLOSED: begin
                tl_d  = '0;
                bad_d = inner_sw | evac_req_i;
                if (outer_sw) begin
                    state_d = OUTER_OPEN;
                end else if (press_req_i) begin
                    state_d = PRESS;
                    tl_d    = CNT_W'(PRESS_TIME);
                end
            end
            OUTER_OPEN: begin
                tl_d  = '0;
                bad_d = inner_sw | evac_req_i | press_req_i;
                if (!outer_sw || door_expire) begin
                    state_d = V_CLOSED;
                end
            end
            PRESS: begin
                bad_d = inner_sw | outer_sw;
                if (evac_req_i) begin
                    state_d = EVAC;
                    tl_d    = reverse_time(tl_q, PRESS_TIME, EVAC_TIME);
                end else if (tick) begin
                    if (tl_q <= CNT_W'(1)) begin
                        state_d = P_CLOSED;
                        tl_d    = '0;
                    end else begin
                        tl_d = tl_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = P_CLOSED;
                tl_d    = '0;
            end
        endcase
    end

    // Prescaler runs only while staying in a timed state; any state change restarts it at 0
    always_comb begin
        presc_d = '0;
        if (presc_run && (state_d == state_q) && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Output decode from the next state so outputs track the state register exactly
    always_comb begin
        inner_open_d = (state_d == INNER_OPEN);
        outer_open_d = (state_d == OUTER_OPEN);
        press_d      = (state_d == P_CLOSED) || (state_d == INNER_OPEN);
        busy_d       = (state_d == EVAC) || (state_d == PRESS);
    end

    // State, countdown, prescaler and registered outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= P_CLOSED;
            tl_q         <= '0;
            presc_q      <= '0;
            bad_q        <= 1'b0;
            inner_open_q <= 1'b0;
            outer_open_q <= 1'b0;
            press_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tl_q         <= tl_d;
            presc_q      <= presc_d;
            bad_q        <= bad_d;
            inner_open_q <= inner_open_d;
            outer_open_q <= outer_open_d;
            press_q      <= press_d;
            busy_q       <= busy_d;
        end
    end

    assign inner_open_o  = inner_open_q;
    assign outer_open_o  = outer_open_q;
    assign pressurized_o = press_q;
    assign busy_o        = busy_q;
    assign time_left_o   = tl_q;
    assign state_o       = state_q;
    assign bad_req_o     = bad_q;

endmodule

// File: tb/tb_airlock_interlock_ctrl.sv
// Bench for airlock_interlock_ctrl: cycle-count model of the airlock plus directed
// literal checks; all checking runs in the single stimulus process.
module tb_airlock_interlock_ctrl;

    localparam int TD = 2;
    localparam int EV = 3;
    localparam int PR = 2;
    localparam int CW = 4;
    localparam int DT = 2;
`ifdef AUTO_CLOSE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inner_sw = 1'b0;
    logic          outer_sw = 1'b0;
    logic          evac_req = 1'b0;
    logic          press_req = 1'b0;
    logic          inner_open, outer_open, pressurized, busy, bad_req;
    logic [CW-1:0] time_left;
    logic [2:0]    state;
    logic          forced_act;
`ifdef AUTO_CLOSE_EN
    logic          door_forced;
    assign forced_act = door_forced;
`else
    assign forced_act = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Model: location code, pump duration in ticks, cycles spent pumping / with a door open.
    int m_st, m_total, m_el, m_del;
    bit m_bad, m_forced, m_ilock, m_olock;
    bit prev_inner, prev_outer, prev_busy;

    airlock_interlock_ctrl #(
        .TICK_DIV(TD), .EVAC_TIME(EV), .PRESS_TIME(PR), .CNT_W(CW), .DOOR_TIMEOUT(DT)
    ) dut (
        .Clock(clk),
        .Reset_n(rst_n),
        .inner_sw_i(inner_sw),
        .outer_sw_i(outer_sw),
        .evac_req_i(evac_req),
        .press_req_i(press_req),
        .inner_open_o(inner_open),
        .outer_open_o(outer_open),
        .pressurized_o(pressurized),
        .busy_o(busy),
        .time_left_o(time_left),
        .state_o(state),
        .bad_req_o(bad_req)
`ifdef AUTO_CLOSE_EN
        ,
        .door_forced_o(door_forced)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_total = 0; m_el = 0; m_del = 0;
        m_bad = 0; m_forced = 0; m_ilock = 0; m_olock = 0;
        prev_inner = 0; prev_outer = 0; prev_busy = 0;
    endtask

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Advance the model by one rising edge using the inputs the DUT will sample.
    task automatic model_next();
        bit iw, ow;
        int rem;
        if (!rst_n) begin
            model_reset();
            return;
        end
        iw = inner_sw && !m_ilock;
        ow = outer_sw && !m_olock;
        if (!inner_sw) m_ilock = 0;
        if (!outer_sw) m_olock = 0;
        m_forced = 0;
        rem = m_total - m_el / TD;
        case (m_st)
            0: begin
                m_bad = ow || press_req;
                if (iw) begin m_st = 1; m_del = 0; end
                else if (evac_req) begin m_st = 2; m_total = EV; m_el = 0; end
            end
            1: begin
                m_bad = ow || evac_req || press_req;
                if (!iw) m_st = 0;
                else begin
                    m_del++;
                    if (AUTO && m_del == DT * TD) begin m_st = 0; m_forced = 1; m_ilock = 1; end
                end
            end
            2: begin
                m_bad = iw || ow;
                if (press_req) begin m_st = 5; m_total = max1(PR - rem * PR / EV); m_el = 0; end
                else begin
                    m_el++;
                    if (m_el == m_total * TD) m_st = 3;
                end
            end
            3: begin
                m_bad = iw || evac_req;
                if (ow) begin m_st = 4; m_del = 0; end
                else if (press_req) begin m_st = 5; m_total = PR; m_el = 0; end
            end
            4: begin
                m_bad = iw || evac_req || press_req;
                if (!ow) m_st = 3;
                else begin
                    m_del++;
                    if (AUTO && m_del == DT * TD) begin m_st = 3; m_forced = 1; m_olock = 1; end
                end
            end
            default: begin
                m_bad = iw || ow;
                if (evac_req) begin m_st = 2; m_total = max1(EV - rem * EV / PR); m_el = 0; end
                else begin
                    m_el++;
                    if (m_el == m_total * TD) m_st = 0;
                end
            end
        endcase
    endtask

    // Per-cycle comparison against the model plus the door interlock invariant.
    task automatic compare();
        logic [12:0] act, exp;
        int tl;
        bit pumping;
        pumping = (m_st == 2) || (m_st == 5);
        tl = pumping ? (m_total - m_el / TD) : 0;
        exp = {3'(m_st), m_st == 1, m_st == 4, m_st <= 1, pumping, 4'(tl), m_bad, m_forced};
        act = {state, inner_open, outer_open, pressurized, busy, time_left, bad_req, forced_act};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t {st,in,out,prs,busy,tl,bad,frc} got=%b want=%b", $time, act, exp);
        end
        checks++;
        if ((inner_open && outer_open) ||
            (prev_busy && ((inner_open && !prev_inner) || (outer_open && !prev_outer)))) begin
            errors++;
            $display("FAIL door_interlock t=%0t inner=%b outer=%b prev_busy=%b", $time, inner_open, outer_open, prev_busy);
        end
        prev_inner = inner_open;
        prev_outer = outer_open;
        prev_busy  = busy;
    endtask

    task automatic step();
        model_next();
        @(negedge clk);
        compare();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    initial begin
        model_reset();
        step();
        step();
        chk("rst_state", int'(state), 0);
        chk("rst_pressurized", int'(pressurized), 1);
        chk("rst_doors", int'({inner_open, outer_open}), 0);
        chk("rst_time_left", int'(time_left), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Evacuate with the outer switch held: refused in P_CLOSED and during EVAC.
        outer_sw = 1'b1; evac_req = 1'b1;
        step();
        chk("evac_state", int'(state), 2);
        chk("evac_busy", int'(busy), 1);
        chk("evac_tl_start", int'(time_left), 3);
        chk("pclosed_outer_refused", int'(bad_req), 1);
        evac_req = 1'b0;
        step();
        chk("evac_outer_refused", int'(bad_req), 1);
        chk("evac_outer_shut", int'(outer_open), 0);
        step();
        chk("evac_tl_2", int'(time_left), 2);
        step(); step();
        chk("evac_tl_1", int'(time_left), 1);
        step(); step();
        chk("vclosed_state", int'(state), 3);
        chk("vclosed_pressurized", int'(pressurized), 0);
        step();
        chk("outer_open", int'(outer_open), 1);
        inner_sw = 1'b1;
        step();
        chk("outer_inner_refused", int'(bad_req), 1);
        chk("outer_inner_shut", int'(inner_open), 0);
        inner_sw = 1'b0; outer_sw = 1'b0;
        step();
        chk("back_vclosed", int'(state), 3);

        // Full pressurise cycle.
        press_req = 1'b1;
        step();
        chk("press_state", int'(state), 5);
        chk("press_tl_start", int'(time_left), 2);
        press_req = 1'b0;
        repeat (4) step();
        chk("press_done_state", int'(state), 0);
        chk("press_done_pressurized", int'(pressurized), 1);

        // Reversal with time_left=2: 2 - 2*2/3 = 1.
        evac_req = 1'b1;
        step();
        evac_req = 1'b0;
        step(); step();
        chk("rev_pre_tl", int'(time_left), 2);
        press_req = 1'b1;
        step();
        chk("rev_state", int'(state), 5);
        chk("rev_tl", int'(time_left), 1);
        press_req = 1'b0;
        step(); step();
        chk("rev_done_state", int'(state), 0);

        // Door request wins over simultaneous evacuation request.
        inner_sw = 1'b1; evac_req = 1'b1;
        step();
        chk("prio_state", int'(state), 1);
        chk("prio_inner_open", int'(inner_open), 1);
        chk("prio_busy", int'(busy), 0);
        inner_sw = 1'b0; evac_req = 1'b0;
        step();
        chk("prio_closed", int'(state), 0);

`ifdef AUTO_CLOSE_EN
        // Held inner switch: forced shut after DT ticks, then locked out until released.
        inner_sw = 1'b1;
        step();
        chk("auto_open", int'(inner_open), 1);
        repeat (3) step();
        chk("auto_still_open", int'(inner_open), 1);
        step();
        chk("auto_forced_shut", int'(inner_open), 0);
        chk("auto_forced_pulse", int'(door_forced), 1);
        step();
        chk("auto_pulse_end", int'(door_forced), 0);
        step();
        chk("auto_lockout", int'(inner_open), 0);
        inner_sw = 1'b0;
        step();
        inner_sw = 1'b1;
        step();
        chk("auto_reopen", int'(inner_open), 1);
        inner_sw = 1'b0;
        step();
`endif

        // Asynchronous reset while the outer door is open.
        evac_req = 1'b1;
        step();
        evac_req = 1'b0;
        repeat (6) step();
        chk("rst_path_vclosed", int'(state), 3);
        outer_sw = 1'b1;
        step();
        chk("rst_path_outer", int'(state), 4);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_outer", int'(outer_open), 0);
        chk("async_rst_pressurized", int'(pressurized), 1);
        chk("async_rst_tl", int'(time_left), 0);
        outer_sw = 1'b0;
        #1 rst_n = 1'b1;
        step();
        step();
        chk("post_rst_state", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
